start_sig_master: RTL and testbench

Initiator side of the start_sig/done_sig handshake used by our sequenced sub-blocks. On a go pulse it drives start_sig high to a responder and holds it until the responder returns a one-cycle done_sig. It releases start_sig for exactly one cycle, then repeats for N_RUNS transactions. It reports busy, run index, per-run cycle count, completion and watchdog timeout. It sits between top-level control and any start_sig-driven worker block.

---
 rtl/start_sig_master.sv | 143 ++++++++++++++
 tb/tb_start_sig_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/start_sig_master.sv
// Initiator side of the start_sig/done_sig handshake: runs N_RUNS request/acknowledge
// transactions per go pulse, with per-run cycle count, watchdog timeout and abort.
module start_sig_master #(
  parameter int N_RUNS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  input  logic        done_sig,
  output logic        start_sig,
  output logic        busy,
  output logic [7:0]  run_idx,
  output logic [15:0] run_cycles,
  output logic        finish_sig,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  // Handshake: start_sig is a level held until the responder returns a single-cycle
  // done_sig; done_sig is only accepted while start_sig is high (ASSERT state).
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_e;

  localparam logic [7:0]  LAST_IDX = 8'(N_RUNS - 1);
  localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic [7:0]  run_idx_q, run_idx_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic        finish_q, finish_d;
  logic        terr_q, terr_d;
  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    run_idx_d    = run_idx_q;
    run_cycles_d = run_cycles_q;
    finish_d     = 1'b0;
    terr_d       = terr_q;
    wdog_d       = wdog_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = ASSERT;
          start_d   = 1'b1;
          run_idx_d = 8'd0;
          wdog_d    = 16'd0;
          terr_d    = 1'b0;
        end
      end
      ASSERT: begin
        // done_sig takes precedence over a watchdog expiry in the same cycle
        if (done_sig) begin
          run_cycles_d = wdog_q + 16'd1;
          start_d      = 1'b0;
          if (run_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            run_idx_d = run_idx_q + 8'd1;
            state_d   = RELEASE;
          end
        end else if (wdog_q == WDOG_MAX) begin
          start_d = 1'b0;
          terr_d  = 1'b1;
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      RELEASE: begin
        wdog_d  = 16'd0;
        start_d = 1'b1;
        state_d = ASSERT;
      end
      DONE, ERR: begin
        // Two cycles here: the first arms finish_sig, the second returns to IDLE
        if (finish_q) begin
          state_d = IDLE;
        end else begin
          finish_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      start_d      = 1'b0;
      finish_d     = 1'b0;
      run_idx_d    = run_idx_q;
      run_cycles_d = run_cycles_q;
      terr_d       = terr_q;
      wdog_d       = wdog_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      run_idx_q    <= 8'd0;
      run_cycles_q <= 16'd0;
      finish_q     <= 1'b0;
      terr_q       <= 1'b0;
      wdog_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      run_idx_q    <= run_idx_d;
      run_cycles_q <= run_cycles_d;
      finish_q     <= finish_d;
      terr_q       <= terr_d;
      wdog_q       <= wdog_d;
    end
  end

  assign start_sig   = start_q;
  assign busy        = busy_q;
  assign run_idx     = run_idx_q;
  assign run_cycles  = run_cycles_q;
  assign finish_sig  = finish_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_start_sig_master.sv
// Directed bench for start_sig_master: expected outputs are derived per cycle from the
// handshake rules by the stimulus tasks and compared every cycle, plus literal pins.
module tb_start_sig_master;

  localparam int N  = 4;
  localparam int TO = 64;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic        abort;
  logic        done_sig;
  logic        start_sig;
  logic        busy;
  logic [7:0]  run_idx;
  logic [15:0] run_cycles;
  logic        finish_sig;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  logic        exp_start, exp_busy, exp_fin, exp_terr;
  logic [7:0]  exp_idx;
  logic [15:0] exp_cycles;

  int n_vec;
  int n_err;
  int busy_cnt, fin_cnt, rise_cnt;
  logic prev_start;

  start_sig_master #(.N_RUNS(N), .TIMEOUT(TO)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .abort      (abort),
    .done_sig   (done_sig),
    .start_sig  (start_sig),
    .busy       (busy),
    .run_idx    (run_idx),
    .run_cycles (run_cycles),
    .finish_sig (finish_sig),
    .timeout_err(timeout_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // per-cycle compare against the model expectations
  always @(negedge clk) begin
    chk("start_sig",   32'(start_sig),   32'(exp_start));
    chk("busy",        32'(busy),        32'(exp_busy));
    chk("run_idx",     32'(run_idx),     32'(exp_idx));
    chk("run_cycles",  32'(run_cycles),  32'(exp_cycles));
    chk("finish_sig",  32'(finish_sig),  32'(exp_fin));
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
  end

  // activity counters used by the literal checks
  initial begin
    busy_cnt = 0; fin_cnt = 0; rise_cnt = 0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (finish_sig) fin_cnt++;
      if (start_sig && !prev_start) rise_cnt++;
      prev_start = start_sig;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_seq();
    go = 1'b1;
    tick();
    go = 1'b0;
    exp_start = 1'b1; exp_busy = 1'b1; exp_idx = 8'd0; exp_terr = 1'b0; exp_fin = 1'b0;
  endtask

  task automatic finish_tail();
    tick(); exp_fin = 1'b1;
    tick(); exp_fin = 1'b0; exp_busy = 1'b0;
  endtask

  // N runs, run r answered on its lat[r]-th start_sig-high cycle
  task automatic run_seq(input int lat [N], input bit spur);
    begin_seq();
    for (int r = 0; r < N; r++) begin
      for (int k = 1; k <= lat[r]; k++) begin
        done_sig = (k == lat[r]);
        tick();
        done_sig = 1'b0;
        if (k == lat[r]) begin
          exp_start  = 1'b0;
          exp_cycles = 16'(lat[r]);
          if (r < N - 1) exp_idx = 8'(r + 1);
        end
      end
      if (r < N - 1) begin
        done_sig = spur;
        tick();
        done_sig = 1'b0;
        exp_start = 1'b1;
      end
    end
    finish_tail();
  endtask

  task automatic run_timeout();
    begin_seq();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO) begin
        exp_start = 1'b0;
        exp_terr  = 1'b1;
      end
    end
    finish_tail();
  endtask

  // run 0 completes after lat0 cycles; abort lands on cycle at_k of run 1
  task automatic run_abort(input int lat0, input int at_k, input bit with_done);
    begin_seq();
    for (int k = 1; k <= lat0; k++) begin
      go       = (k == 3);
      done_sig = (k == lat0);
      tick();
      go = 1'b0; done_sig = 1'b0;
      if (k == lat0) begin
        exp_start = 1'b0; exp_cycles = 16'(lat0); exp_idx = 8'd1;
      end
    end
    tick();
    exp_start = 1'b1;
    for (int k = 1; k <= at_k; k++) begin
      if (k == at_k) begin
        abort = 1'b1; done_sig = with_done;
      end
      tick();
      abort = 1'b0; done_sig = 1'b0;
      if (k == at_k) begin
        exp_start = 1'b0; exp_busy = 1'b0;
      end
    end
    tick();
    tick();
  endtask

  int lat_a [N];
  int lat_b [N];
  int lat_c [N];
  int lat_d [N];
  int b0, f0, r0;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; done_sig = 1'b0;
    exp_start = 1'b0; exp_busy = 1'b0; exp_idx = 8'd0; exp_cycles = 16'd0;
    exp_fin = 1'b0; exp_terr = 1'b0;
    lat_a = '{10, 10, 10, 10};
    lat_b = '{1, 5, 3, 64};
    lat_c = '{2, 2, 2, 2};
    lat_d = '{3, 3, 3, 3};

    tick(); tick();
    rst_n = 1'b1;
    tick();

    // spurious done_sig while idle
    done_sig = 1'b1;
    tick(); tick();
    done_sig = 1'b0;
    tick();

    b0 = busy_cnt; f0 = fin_cnt; r0 = rise_cnt;
    run_seq(lat_a, 1'b0);
    tick();
    chk("lit_cycles_10",   32'(run_cycles), 32'd10);
    chk("lit_busy_45",     32'(busy_cnt - b0), 32'd45);
    chk("lit_one_finish",  32'(fin_cnt - f0), 32'd1);
    chk("lit_four_starts", 32'(rise_cnt - r0), 32'd4);
    chk("lit_last_idx",    32'(run_idx), 32'd3);

    // mixed latencies incl. done on the final watchdog cycle, spurious done in RELEASE
    run_seq(lat_b, 1'b1);
    tick();
    chk("lit_cycles_64", 32'(run_cycles), 32'd64);
    chk("lit_no_terr",   32'(timeout_err), 32'd0);

    f0 = fin_cnt;
    run_timeout();
    tick();
    chk("lit_terr_set",      32'(timeout_err), 32'd1);
    chk("lit_cycles_kept",   32'(run_cycles), 32'd64);
    chk("lit_timeout_fin",   32'(fin_cnt - f0), 32'd1);

    run_seq(lat_c, 1'b0);
    tick();
    chk("lit_terr_cleared", 32'(timeout_err), 32'd0);

    f0 = fin_cnt;
    run_abort(10, 5, 1'b0);
    chk("lit_abort_idx",    32'(run_idx), 32'd1);
    chk("lit_abort_nofin",  32'(fin_cnt - f0), 32'd0);

    run_abort(4, 7, 1'b1);
    chk("lit_abort_done_cycles", 32'(run_cycles), 32'd4);

    // asynchronous reset in the middle of an ASSERT window
    begin_seq();
    tick(); tick();
    #2;
    rst_n = 1'b0;
    exp_start = 1'b0; exp_busy = 1'b0; exp_idx = 8'd0; exp_cycles = 16'd0;
    exp_fin = 1'b0; exp_terr = 1'b0;
    #1;
    chk("lit_rst_start",  32'(start_sig), 32'd0);
    chk("lit_rst_busy",   32'(busy), 32'd0);
    chk("lit_rst_cycles", 32'(run_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_seq(lat_d, 1'b0);
    tick();
    chk("lit_post_reset_cycles", 32'(run_cycles), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
